clk_en_sched: RTL and testbench
===============================

Name: clk_en_sched

Overview:
Clock-enable scheduler for the FSK demodulator. It generates single-cycle enable strobes on the 200 MHz system clock, so downstream logic never uses fabric-derived clocks. The strobes are:
- smp_en: sample strobe.
- sym_en: symbol strobe, one per sample-per-symbol group.
- ip_en: IP-core strobe.

It also provides run/stop sequencing, a configuration handshake, and symbol-phase resync requested by the bit-sync loop.

Parameters:
- CNT_W, 16, width of the sample-divider counter and of cfg_smp_div.
- SMP_DIV, 360, default system clocks per sample.
- SYM_RATIO, 32, default samples per symbol.
- IP_DIV, 8, system clocks per ip_en; fixed, not runtime-configurable.

Ports:
- clk  in  1  200 MHz system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; high requests strobe generation.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high only in IDLE.
- cfg_smp_div  in  CNT_W  clocks per sample.
- cfg_sym_ratio  in  8  samples per symbol.
- resync  in  1  single-cycle symbol-phase realign request.
- smp_en  out  1  sample strobe.
- sym_en  out  1  symbol strobe; only ever asserted together with smp_en.
- ip_en  out  1  IP-core strobe.
- busy  out  1  state != IDLE.
- cfg_err  out  1  sticky flag: an illegal configuration was clamped.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset:
  - state = IDLE; all counters 0.
  - Active divisors = SMP_DIV / SYM_RATIO.
  - smp_en, sym_en, ip_en, busy, cfg_err = 0.
  - rst mid-RUN aborts immediately; no strobe in the cycle following rst.
- FSM states: IDLE, RUN, STOP.
  - IDLE -> RUN when run=1. Counters are already 0.
  - RUN -> STOP when run=0.
  - STOP -> RUN when run=1 (counters keep their phase).
  - STOP -> IDLE in the cycle after sym_en fires, so the last symbol always completes.
  - STOP with run still 0 keeps counting and strobing normally.
- Counters:
  - smp_cnt runs 0..div-1 with wrap-around; it advances in RUN/STOP and holds 0 in IDLE.
  - sym_cnt runs 0..ratio-1 and advances on each smp_en.
  - ip_cnt runs 0..IP_DIV-1 in RUN/STOP only.
- Strobe timing (strobes decoded from registered counters, one cycle wide):
  - smp_en = (smp_cnt == div-1).
  - sym_en = smp_en AND (sym_cnt == ratio-1).
  - ip_en = (ip_cnt == IP_DIV-1).
  - Taking RUN cycle 0 as the first cycle in RUN, smp_en is high on cycles k·div + div-1.
  - With defaults: first smp_en on cycle 359, first sym_en on cycle 11519, ip_en every 8 cycles starting at cycle 7.
- Configuration handshake:
  - A transfer occurs when cfg_valid and cfg_ready are both high; values take effect from the next IDLE->RUN.
  - cfg_ready is 0 in RUN and STOP; offers made then wait (valid is held by the master).
  - Clamping: cfg_smp_div < 2 is clamped to 2; cfg_sym_ratio = 0 is clamped to 1. Either clamp sets cfg_err, which is cleared only by rst.
- Resync (honoured in RUN and STOP; ignored in IDLE):
  - The cycle-t strobes are still output as decoded.
  - smp_cnt and sym_cnt load 0 at t+1; ip_cnt is unaffected.
  - The next smp_en follows div cycles after t+1, i.e. at t+div.
  - resync coinciding with the STOP->IDLE transition: IDLE wins.
- Simultaneous run=0 and resync: enter STOP and apply the resync.

Optional Feature:
- Macro CLK_EN_SCHED_STATS_EN.
- When defined, adds two outputs, both cleared by rst:
  - sym_count[15:0]: increments on each sym_en and wraps at 0xFFFF->0.
  - resync_count[7:0]: counts honoured resyncs and saturates at 255.
- When undefined, neither port nor its logic exists.

Decomposition:
- Package clk_en_sched_pkg holds:
  - The state enum {IDLE, RUN, STOP}.
  - Defaults CLK_HZ = 200_000_000, SMP_DIV_DEF = 360, SYM_RATIO_DEF = 32, IP_DIV_DEF = 8.
  - Minimums SMP_DIV_MIN = 2, SYM_RATIO_MIN = 1.
- One sub-module, en_div_cnt: a parameterised-width terminal-count counter with inputs en, clr, limit and output tc. It is instantiated three times (sample, symbol, IP).

Test Plan:
1. Defaults, rst then run=1 -> smp_en on cycles 359/719; sym_en only on cycle 11519; ip_en on 7, 15, …; busy=1.
2. In IDLE, offer cfg_smp_div=10, cfg_sym_ratio=4, then run -> smp_en every 10 cycles, sym_en on cycle 39. A cfg_valid raised during RUN sees cfg_ready=0 and the active settings are unchanged.
3. Offer cfg_smp_div=1, cfg_sym_ratio=0 -> behaves as 2/1, so smp_en and sym_en fire together every 2 cycles; cfg_err=1 until rst.
4. div=10, ratio=4, resync at RUN cycle 15 -> next smp_en at cycle 25; sym_en at cycle 55; ip_en phase unchanged.
5. div=10, ratio=4, run drops at cycle 12 -> strobes continue; sym_en at 39; busy=0 and IDLE from cycle 40; no strobes afterwards.
6. rst asserted at RUN cycle 200 -> all outputs 0 in the next cycle; state IDLE; a fresh run restarts with first smp_en 359 cycles later (default config).

Source files
------------

// File: rtl/clk_en_sched_pkg.sv
// Shared types and defaults for the clock-enable scheduler.
package clk_en_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ        = 200_000_000;
  localparam int unsigned SMP_DIV_DEF   = 360;
  localparam int unsigned SYM_RATIO_DEF = 32;
  localparam int unsigned IP_DIV_DEF    = 8;
  localparam int unsigned SMP_DIV_MIN   = 2;
  localparam int unsigned SYM_RATIO_MIN = 1;
  localparam int unsigned RATIO_W       = 8;

endpackage

// File: rtl/en_div_cnt.sv
// Terminal-count counter: counts 0..limit while en, wraps after limit, clr forces 0.
module en_div_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt >= limit) ? '0 : cnt + W'(1);
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: sample/symbol/IP strobes with run/stop sequencing and resync.
// Optional statistics outputs enabled by defining CLK_EN_SCHED_STATS_EN.
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SMP_DIV   = SMP_DIV_DEF,
  parameter int unsigned SYM_RATIO = SYM_RATIO_DEF,
  parameter int unsigned IP_DIV    = IP_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_smp_div,
  input  logic [RATIO_W-1:0] cfg_sym_ratio,
  input  logic               resync,
  output logic               smp_en,
  output logic               sym_en,
  output logic               ip_en,
  output logic               busy,
`ifdef CLK_EN_SCHED_STATS_EN
  output logic [15:0]        sym_count,
  output logic [7:0]         resync_count,
`endif
  output logic               cfg_err
);

  localparam int unsigned IP_W = (IP_DIV > 2) ? $clog2(IP_DIV) : 1;

  state_t state, state_n;

  logic [CNT_W-1:0]   div_act;
  logic [RATIO_W-1:0] ratio_act;
  logic               running;
  logic               resync_hon;
  logic               go_idle;
  logic               cnt_clr;
  logic               cfg_fire;
  logic               div_low;
  logic               ratio_low;
  logic               smp_tc;
  logic               sym_tc;
  logic               ip_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and strobe decode; STOP drains until the current symbol completes.
  always_comb begin
    state_n    = state;
    running    = 1'b0;
    resync_hon = 1'b0;
    smp_en     = 1'b0;
    sym_en     = 1'b0;
    ip_en      = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_n = RUN;
      end
      RUN: begin
        running = 1'b1;
        if (!run) state_n = STOP;
      end
      STOP: begin
        running = 1'b1;
        if (smp_tc && sym_tc) state_n = IDLE;
        else if (run)         state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
    if (running) begin
      resync_hon = resync;
      smp_en     = smp_tc;
      sym_en     = smp_tc & sym_tc;
      ip_en      = ip_tc;
    end
  end

  assign go_idle   = (state_n == IDLE);
  assign cnt_clr   = go_idle | resync_hon;
  assign busy      = running;
  assign cfg_ready = (state == IDLE);

  // Configuration only accepted in IDLE, so counters are at 0 when it lands.
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign div_low   = (cfg_smp_div < CNT_W'(SMP_DIV_MIN));
  assign ratio_low = (cfg_sym_ratio < RATIO_W'(SYM_RATIO_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_act   <= CNT_W'(SMP_DIV);
      ratio_act <= RATIO_W'(SYM_RATIO);
      cfg_err   <= 1'b0;
    end else if (cfg_fire) begin
      div_act   <= div_low ? CNT_W'(SMP_DIV_MIN) : cfg_smp_div;
      ratio_act <= ratio_low ? RATIO_W'(SYM_RATIO_MIN) : cfg_sym_ratio;
      if (div_low || ratio_low) cfg_err <= 1'b1;
    end
  end

  en_div_cnt #(.W(CNT_W)) u_smp_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (running),
    .clr   (cnt_clr),
    .limit (div_act - CNT_W'(1)),
    .tc    (smp_tc)
  );

  en_div_cnt #(.W(RATIO_W)) u_sym_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (running & smp_tc),
    .clr   (cnt_clr),
    .limit (ratio_act - RATIO_W'(1)),
    .tc    (sym_tc)
  );

  // IP phase is independent of symbol resync.
  en_div_cnt #(.W(IP_W)) u_ip_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (running),
    .clr   (go_idle),
    .limit (IP_W'(IP_DIV - 1)),
    .tc    (ip_tc)
  );

`ifdef CLK_EN_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_count    <= '0;
      resync_count <= '0;
    end else begin
      if (sym_en) sym_count <= sym_count + 16'd1;
      if (resync_hon && (resync_count != 8'hFF)) resync_count <= resync_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed self-checking bench for clk_en_sched.
module tb_clk_en_sched;
  import clk_en_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_smp_div = '0;
  logic [7:0]  cfg_sym_ratio = '0;
  logic        resync = 1'b0;
  logic        smp_en, sym_en, ip_en, busy, cfg_err;
`ifdef CLK_EN_SCHED_STATS_EN
  logic [15:0] sym_count;
  logic [7:0]  resync_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int first_smp, second_smp, first_sym, first_ip;
  int n_smp, n_sym, n_ip, orphan_sym, idle_at;

  always #5 clk = ~clk;

  clk_en_sched dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_smp_div   (cfg_smp_div),
    .cfg_sym_ratio (cfg_sym_ratio),
    .resync        (resync),
    .smp_en        (smp_en),
    .sym_en        (sym_en),
    .ip_en         (ip_en),
    .busy          (busy),
`ifdef CLK_EN_SCHED_STATS_EN
    .sym_count     (sym_count),
    .resync_count  (resync_count),
`endif
    .cfg_err       (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; resync = 1'b0;
    step();
    rst = 1'b0;
    check("rst smp_en", 32'(smp_en), 0);
    check("rst sym_en", 32'(sym_en), 0);
    check("rst ip_en", 32'(ip_en), 0);
    check("rst busy", 32'(busy), 0);
    check("rst cfg_err", 32'(cfg_err), 0);
    check("rst cfg_ready", 32'(cfg_ready), 1);
  endtask

  task automatic configure(input int div, input int ratio);
    cfg_valid = 1'b1;
    cfg_smp_div = 16'(div);
    cfg_sym_ratio = 8'(ratio);
    step();
    cfg_valid = 1'b0;
  endtask

  // Caller is positioned in RUN cycle 0; observes n cycles and records strobe positions.
  task automatic watch(input int n, input int resync_at, input int drop_at, input int rst_at);
    first_smp = -1; second_smp = -1; first_sym = -1; first_ip = -1;
    n_smp = 0; n_sym = 0; n_ip = 0; orphan_sym = 0; idle_at = -1;
    for (int c = 0; c < n; c++) begin
      if (smp_en) begin
        if (first_smp < 0) first_smp = c;
        else if (second_smp < 0) second_smp = c;
        n_smp++;
      end
      if (sym_en) begin
        if (first_sym < 0) first_sym = c;
        n_sym++;
        if (!smp_en) orphan_sym++;
      end
      if (ip_en) begin
        if (first_ip < 0) first_ip = c;
        n_ip++;
      end
      if (!busy && idle_at < 0) idle_at = c;
      resync = (c == resync_at);
      if (c == drop_at) run = 1'b0;
      if (rst_at >= 0 && c == rst_at) begin
        rst = 1'b1;
        run = 1'b0;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("post-rst smp_en", 32'(smp_en), 0);
        check("post-rst sym_en", 32'(sym_en), 0);
        check("post-rst ip_en", 32'(ip_en), 0);
        check("post-rst busy", 32'(busy), 0);
        check("post-rst cfg_ready", 32'(cfg_ready), 1);
        rst = 1'b0;
      end
      step();
    end
    resync = 1'b0;
  endtask

  initial begin
    // 1: defaults
    do_reset();
    run = 1'b1;
    step();
    check("t1 busy", 32'(busy), 1);
    check("t1 cfg_ready", 32'(cfg_ready), 0);
    watch(11530, -1, -1, -1);
    check("t1 first smp", 32'(first_smp), 359);
    check("t1 second smp", 32'(second_smp), 719);
    check("t1 n smp", 32'(n_smp), 32);
    check("t1 first sym", 32'(first_sym), 11519);
    check("t1 n sym", 32'(n_sym), 1);
    check("t1 first ip", 32'(first_ip), 7);
    check("t1 n ip", 32'(n_ip), 1441);
    check("t1 orphan sym", 32'(orphan_sym), 0);

    // 2: runtime config 10/4; offer during RUN is not accepted
    do_reset();
    configure(10, 4);
    check("t2 cfg_err", 32'(cfg_err), 0);
    run = 1'b1;
    step();
    cfg_valid = 1'b1; cfg_smp_div = 16'd20; cfg_sym_ratio = 8'd2;
    check("t2 cfg_ready in run", 32'(cfg_ready), 0);
    watch(45, -1, -1, -1);
    check("t2 first smp", 32'(first_smp), 9);
    check("t2 second smp", 32'(second_smp), 19);
    check("t2 n smp", 32'(n_smp), 4);
    check("t2 first sym", 32'(first_sym), 39);
    check("t2 n sym", 32'(n_sym), 1);
    check("t2 n ip", 32'(n_ip), 5);
    check("t2 cfg_ready held", 32'(cfg_ready), 0);

    // 3: illegal config clamps to 2/1
    do_reset();
    configure(1, 0);
    check("t3 cfg_err set", 32'(cfg_err), 1);
    run = 1'b1;
    step();
    watch(10, -1, -1, -1);
    check("t3 first smp", 32'(first_smp), 1);
    check("t3 second smp", 32'(second_smp), 3);
    check("t3 n smp", 32'(n_smp), 5);
    check("t3 first sym", 32'(first_sym), 1);
    check("t3 n sym", 32'(n_sym), 5);
    check("t3 cfg_err sticky", 32'(cfg_err), 1);

    // 4: resync at cycle 15
    do_reset();
    configure(10, 4);
    run = 1'b1;
    step();
    watch(60, 15, -1, -1);
    check("t4 first smp", 32'(first_smp), 9);
    check("t4 smp after resync", 32'(second_smp), 25);
    check("t4 n smp", 32'(n_smp), 5);
    check("t4 first sym", 32'(first_sym), 55);
    check("t4 n sym", 32'(n_sym), 1);
    check("t4 first ip", 32'(first_ip), 7);
    check("t4 n ip", 32'(n_ip), 7);
`ifdef CLK_EN_SCHED_STATS_EN
    check("t4 resync_count", 32'(resync_count), 1);
`endif

    // 5: run drops at cycle 12, last symbol completes
    do_reset();
    configure(10, 4);
    run = 1'b1;
    step();
    watch(60, -1, 12, -1);
    check("t5 n smp", 32'(n_smp), 4);
    check("t5 first sym", 32'(first_sym), 39);
    check("t5 n sym", 32'(n_sym), 1);
    check("t5 n ip", 32'(n_ip), 5);
    check("t5 idle at", 32'(idle_at), 40);
    check("t5 cfg_ready", 32'(cfg_ready), 1);

    // 6: rst at RUN cycle 200, then fresh run
    do_reset();
    run = 1'b1;
    step();
    watch(210, -1, -1, 200);
    check("t6 no smp", 32'(n_smp), 0);
    check("t6 n ip", 32'(n_ip), 25);
    check("t6 idle at", 32'(idle_at), 201);
    run = 1'b1;
    step();
    watch(400, -1, -1, -1);
    check("t6 restart first smp", 32'(first_smp), 359);
    check("t6 restart n smp", 32'(n_smp), 1);
    check("t6 restart first ip", 32'(first_ip), 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
